// File: rtl/tmds_video_sequencer.sv
// 640x480@60 raster sequencer: generates timing, fetches pixels over req/resp,
// and emits DVI 8b/10b TMDS symbols (control tokens during blanking).
module tmds_video_sequencer #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic        pixclk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        tmds_locked,
    output logic        pix_req,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    input  logic [23:0] pix_rgb,
    output logic        frame_start,
    output logic        running,
    output logic [9:0]  TMDS_red,
    output logic [9:0]  TMDS_green,
    output logic [9:0]  TMDS_blue
);

    // state | meaning
    // OFF   | raster held at (0,0), outputs idle token, disparity cleared
    // RUN   | raster advancing, pipeline fetching and encoding
    typedef enum logic {OFF = 1'b0, RUN = 1'b1} state_t;

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] TOK_00   = 10'b1101010100;

    state_t      state, state_nxt;
    logic [9:0]  h, v;
    logic        run_now, last_pos, active0, hs0, vs0;
    logic        de1, de2, de3;
    logic [1:0]  c1, c2, c3;
    logic [23:0] rgb_q;
    logic signed [4:0] cnt_r, cnt_g, cnt_b;
    logic [14:0] enc_r, enc_g, enc_b;

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    // Returns {next running disparity, 10-bit symbol}.
    function automatic logic [14:0] tmds_encode(input logic [7:0] d, input logic signed [4:0] cnt);
        logic [3:0] n1d, n1q;
        logic [8:0] qm;
        logic       use_xnor;
        logic signed [5:0] diff, c6, r6;
        logic [9:0] q;
        n1d = 4'd0;
        for (int i = 0; i < 8; i++) n1d = n1d + {3'd0, d[i]};
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~use_xnor;
        n1q = 4'd0;
        for (int i = 0; i < 8; i++) n1q = n1q + {3'd0, qm[i]};
        diff = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
        c6   = {cnt[4], cnt};
        if (cnt == 5'sd0 || diff == 6'sd0) begin
            q  = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            r6 = qm[8] ? c6 + diff : c6 - diff;
        end else if ((!cnt[4] && diff > 6'sd0) || (cnt[4] && diff < 6'sd0)) begin
            q  = {1'b1, qm[8], ~qm[7:0]};
            r6 = c6 + (qm[8] ? 6'sd2 : 6'sd0) - diff;
        end else begin
            q  = {1'b0, qm[8], qm[7:0]};
            r6 = c6 - (qm[8] ? 6'sd0 : 6'sd2) + diff;
        end
        return {r6[4:0], q};
    endfunction

    assign run_now  = (state == RUN) && tmds_locked;
    assign last_pos = (h == H_LAST) && (v == V_LAST);
    assign running  = (state == RUN);

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) state <= OFF;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            OFF:     if (enable && tmds_locked) state_nxt = RUN;
            RUN:     if (!tmds_locked || (last_pos && !enable)) state_nxt = OFF;
            default: state_nxt = OFF;
        endcase
    end

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (!run_now) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
        end else begin
            h <= h + 10'd1;
        end
    end

    assign active0 = (h < H_ACT) && (v < V_ACT);
    assign hs0     = (h >= HS_START && h < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vs0     = (v >= VS_START && v < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

    // Every stage clears whenever the raster is not running, so a lock drop
    // or stop flushes straight to the idle token.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            pix_req <= 1'b0; pix_x <= '0; pix_y <= '0; frame_start <= 1'b0;
            de1 <= 1'b0; de2 <= 1'b0; de3 <= 1'b0;
            c1 <= 2'b00; c2 <= 2'b00; c3 <= 2'b00;
            rgb_q <= '0;
        end else if (!run_now) begin
            pix_req <= 1'b0; pix_x <= '0; pix_y <= '0; frame_start <= 1'b0;
            de1 <= 1'b0; de2 <= 1'b0; de3 <= 1'b0;
            c1 <= 2'b00; c2 <= 2'b00; c3 <= 2'b00;
            rgb_q <= '0;
        end else begin
            pix_req     <= active0;
            pix_x       <= h;
            pix_y       <= v;
            frame_start <= (h == 10'd0) && (v == 10'd0);
            de1 <= active0; c1 <= {vs0, hs0};
            de2 <= de1;     c2 <= c1;
            de3 <= de2;     c3 <= c2;
            rgb_q <= pix_rgb;
        end
    end

    always_comb begin
        enc_r = tmds_encode(rgb_q[23:16], cnt_r);
        enc_g = tmds_encode(rgb_q[15:8],  cnt_g);
        enc_b = tmds_encode(rgb_q[7:0],   cnt_b);
    end

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            TMDS_red <= TOK_00; TMDS_green <= TOK_00; TMDS_blue <= TOK_00;
            cnt_r <= '0; cnt_g <= '0; cnt_b <= '0;
        end else if (!run_now) begin
            TMDS_red <= TOK_00; TMDS_green <= TOK_00; TMDS_blue <= TOK_00;
            cnt_r <= '0; cnt_g <= '0; cnt_b <= '0;
        end else if (de3) begin
            TMDS_red   <= enc_r[9:0];
            TMDS_green <= enc_g[9:0];
            TMDS_blue  <= enc_b[9:0];
            cnt_r <= $signed(enc_r[14:10]);
            cnt_g <= $signed(enc_g[14:10]);
            cnt_b <= $signed(enc_b[14:10]);
        end else begin
            TMDS_red   <= TOK_00;
            TMDS_green <= TOK_00;
            TMDS_blue  <= ctrl_token(c3);
            cnt_r <= '0; cnt_g <= '0; cnt_b <= '0;
        end
    end

endmodule

// File: tb/tb_tmds_video_sequencer.sv
// Bench for tmds_video_sequencer on a reduced raster; expectations come from a
// cycle-history model (absolute raster position per cycle) plus a DVI encoder model.
module tb_tmds_video_sequencer;

    localparam int HA = 16, HFP = 4, HS = 6, HB = 6;
    localparam int VA = 10, VFP = 2, VS = 2, VB = 4;
    localparam int HT = HA + HFP + HS + HB;
    localparam int VT = VA + VFP + VS + VB;
    localparam int F  = HT * VT;
    localparam logic [9:0] TOK00 = 10'b1101010100;

    logic        pixclk = 1'b0;
    logic        rst_n, enable, tmds_locked;
    logic        pix_req, frame_start, running;
    logic [9:0]  pix_x, pix_y, TMDS_red, TMDS_green, TMDS_blue;
    logic [23:0] pix_rgb;

    always #5 pixclk = ~pixclk;

    tmds_video_sequencer #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
        .SYNC_ACTIVE(1'b0)
    ) dut (
        .pixclk(pixclk), .rst_n(rst_n), .enable(enable), .tmds_locked(tmds_locked),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .running(running),
        .TMDS_red(TMDS_red), .TMDS_green(TMDS_green), .TMDS_blue(TMDS_blue)
    );

    int          errors = 0;
    int          checks = 0;
    int          pos_h[$];
    bit          rn_h[$];
    logic [23:0] rgb_h[$];
    int          cyc;
    int          cnt_m[3];
    bit          zero_rgb;
    int          req_count;
    bit          frame_ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [9:0] tok(input int c1, input int c0);
        case (c1 * 2 + c0)
            0:       return 10'b1101010100;
            1:       return 10'b0010101011;
            2:       return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [9:0] dvi_enc(input logic [7:0] d, input int cin, output int cout);
        int n1, ones, zeros;
        bit x;
        logic [8:0] qm;
        logic [9:0] o;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(d[i]);
        x = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = x ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~x;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(qm[i]);
        zeros = 8 - ones;
        if (cin == 0 || ones == zeros) begin
            o    = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cout = qm[8] ? cin + ones - zeros : cin + zeros - ones;
        end else if ((cin > 0 && ones > zeros) || (cin < 0 && zeros > ones)) begin
            o    = {1'b1, qm[8], ~qm[7:0]};
            cout = cin + 2 * int'(qm[8]) + zeros - ones;
        end else begin
            o    = {1'b0, qm[8], qm[7:0]};
            cout = cin - 2 * (1 - int'(qm[8])) + ones - zeros;
        end
        return o;
    endfunction

    task automatic check(input int c);
        int p, h, v, nc, hs, vs;
        bit ereq, efs, valid, act;
        logic [9:0] er, eg, eb;
        logic [23:0] rgb;
        h = 0; v = 0;
        ereq = 1'b0; efs = 1'b0;
        chk("running", 32'(running), 32'(pos_h[c] >= 0));
        if (c >= 1 && rn_h[c-1]) begin
            p = pos_h[c-1]; h = p % HT; v = p / HT;
            ereq = (h < HA) && (v < VA);
            efs  = (p == 0);
        end
        chk("pix_req", 32'(pix_req), 32'(ereq));
        chk("frame_start", 32'(frame_start), 32'(efs));
        if (ereq) begin
            chk("pix_x", 32'(pix_x), h);
            chk("pix_y", 32'(pix_y), v);
        end
        if (c >= 1 && !rn_h[c-1]) frame_ok = 1'b0;
        if (efs) begin
            if (frame_ok) chk("frame_pixels", req_count, HA * VA);
            frame_ok  = 1'b1;
            req_count = 0;
        end
        if (pix_req === 1'b1) req_count++;

        valid = (c >= 4) && rn_h[c-1] && rn_h[c-2] && rn_h[c-3] && rn_h[c-4];
        er = TOK00; eg = TOK00; eb = TOK00;
        act = 1'b0;
        if (valid) begin
            p = pos_h[c-4]; h = p % HT; v = p / HT;
            act = (h < HA) && (v < VA);
            if (act) begin
                rgb = rgb_h[c-2];
                er = dvi_enc(rgb[23:16], cnt_m[0], nc); cnt_m[0] = nc;
                eg = dvi_enc(rgb[15:8],  cnt_m[1], nc); cnt_m[1] = nc;
                eb = dvi_enc(rgb[7:0],   cnt_m[2], nc); cnt_m[2] = nc;
            end else begin
                hs = (h >= HA + HFP && h < HA + HFP + HS) ? 0 : 1;
                vs = (v >= VA + VFP && v < VA + VFP + VS) ? 0 : 1;
                eb = tok(vs, hs);
                cnt_m = '{0, 0, 0};
            end
        end else begin
            cnt_m = '{0, 0, 0};
        end
        chk("tmds_red", 32'(TMDS_red), 32'(er));
        chk("tmds_green", 32'(TMDS_green), 32'(eg));
        chk("tmds_blue", 32'(TMDS_blue), 32'(eb));

        if (valid && act && h == 0 && rgb_h[c-2] == 24'h0) begin
            chk("zero_first_r", 32'(TMDS_red), 32'h100);
            chk("zero_first_b", 32'(TMDS_blue), 32'h100);
        end
        if (valid && act && h == 1 && rgb_h[c-2] == 24'h0 && rgb_h[c-3] == 24'h0) begin
            chk("zero_second_g", 32'(TMDS_green), 32'h3FF);
            chk("zero_second_b", 32'(TMDS_blue), 32'h3FF);
        end
    endtask

    task automatic cycle(input bit rv, input bit ev, input bit lv);
        int p, nx;
        @(negedge pixclk);
        rst_n       = rv;
        enable      = ev;
        tmds_locked = lv;
        pix_rgb     = zero_rgb ? 24'h0 : 24'($urandom);
        p = pos_h[cyc];
        rgb_h.push_back(pix_rgb);
        rn_h.push_back(rv && lv && p >= 0);
        if (!rv)         nx = -1;
        else if (p >= 0) nx = (!lv || (p == F - 1 && !ev)) ? -1 : (p + 1) % F;
        else             nx = (ev && lv) ? 0 : -1;
        @(posedge pixclk);
        #1;
        cyc++;
        pos_h.push_back(nx);
        check(cyc);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; tmds_locked = 1'b1; pix_rgb = 24'h0;
        zero_rgb = 1'b0; cyc = 0; cnt_m = '{0, 0, 0}; req_count = 0; frame_ok = 1'b0;
        @(posedge pixclk);
        #1;
        pos_h.push_back(-1);
        check(0);

        // reset held with enable and lock high
        repeat (3) cycle(1'b0, 1'b1, 1'b1);
        chk("rst_red", 32'(TMDS_red), 32'(TOK00));
        chk("rst_pix_x", 32'(pix_x), 32'd0);

        // release and run two frames of random pixels
        repeat (2 * F + 2) cycle(1'b1, 1'b1, 1'b1);

        // a frame of black pixels
        zero_rgb = 1'b1;
        repeat (F) cycle(1'b1, 1'b1, 1'b1);
        zero_rgb = 1'b0;

        // lock drop mid-line, then relock
        repeat (F / 3 + 7) cycle(1'b1, 1'b1, 1'b1);
        repeat (3) cycle(1'b1, 1'b1, 1'b0);
        repeat (F + 50) cycle(1'b1, 1'b1, 1'b1);

        // stop request cancelled, then a real stop at end of frame
        for (int i = 0; i < F && pos_h[cyc] != 3 * HT; i++) cycle(1'b1, 1'b1, 1'b1);
        repeat (2 * HT) cycle(1'b1, 1'b0, 1'b1);
        repeat (HT) cycle(1'b1, 1'b1, 1'b1);
        repeat (2 * F) cycle(1'b1, 1'b0, 1'b1);
        chk("stopped_running", 32'(running), 32'd0);

        // restart, async reset mid-line, then clean restart
        repeat (F / 2 + 5) cycle(1'b1, 1'b1, 1'b1);
        repeat (2) cycle(1'b0, 1'b1, 1'b1);
        repeat (20) cycle(1'b1, 1'b0, 1'b1);
        repeat (3 * HT) cycle(1'b1, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tmds_video_sequencer.md
# tmds_video_sequencer

Generates 640x480@60 raster timing in the pixel clock domain, fetches pixels from the renderer over a request/response interface, and produces the three 10-bit TMDS symbol words consumed by the 10:1 TMDS serializer. Active video is DVI 8b/10b encoded with per-channel running disparity; blanking carries control tokens. Start/stop is gated by an enable and the serializer clock-lock indication.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SYNC_ACTIVE, 0, sync level during sync region (0 = active-low)
- pixclk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  request to run video
- tmds_locked  in  1  10x serializer clock locked
- pix_req  out  1  pixel fetch strobe, active region only
- pix_x  out  10  column of requested pixel
- pix_y  out  10  row of requested pixel
- pix_rgb  in  24  {R,G,B} response, valid the cycle after pix_req
- frame_start  out  1  one-cycle pulse at h=0,v=0
- running  out  1  raster active
- TMDS_red  out  10  red symbol, bit 0 transmitted first
- TMDS_green  out  10  green symbol
- TMDS_blue  out  10  blue symbol

## Operation
- States: OFF, RUN. Reset -> OFF.
- OFF: counters held at h=0,v=0; all three TMDS outputs = control token C1C0=00 (10'b1101010100); disparity = 0.
- OFF -> RUN when enable && tmds_locked; raster begins at h=0,v=0 with frame_start.
- RUN -> OFF immediately on tmds_locked=0 (pipeline flushed, outputs return to OFF token next cycle).
- enable=0 in RUN: finish current frame; go OFF after h=H_TOTAL-1,v=V_TOTAL-1. Re-asserting enable before then cancels the stop.
- Counters: h 0..H_TOTAL-1 (800), v 0..V_TOTAL-1 (525), 10 bits each. h wraps to 0 and v increments; v wraps at V_TOTAL-1 simultaneously with h wrap.
- Active: h<H_ACTIVE && v<V_ACTIVE. hsync region: H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751). vsync region: lines 490..491.
- Sync level = SYNC_ACTIVE inside region, else ~SYNC_ACTIVE. C0 = hsync level, C1 = vsync level.
- Blanking tokens: blue by {C1,C0}: 00->1101010100, 01->0010101011, 10->0101010100, 11->1010101011. Red and green always 00 token.
- Active: each channel encoded with DVI 1.0 algorithm: XOR/XNOR transition minimization (XNOR when N1>4 or N1==4 and d[0]==0), then DC balance using signed 5-bit running count cnt per channel. cnt reset to 0 whenever DE=0 and in OFF.
- Channel mapping: red=pix_rgb[23:16], green=[15:8], blue=[7:0].

## Timing
- Cycle k: counters at (h,v). Edge end of k: pix_req/pix_x/pix_y/DE/sync registered (valid cycle k+1).
- Requester presents pix_rgb in cycle k+2; sequencer captures it at end of k+2.
- Encoder registered at end of k+3; TMDS outputs valid cycle k+4. DE/sync delayed identically so tokens and data align.
- frame_start asserted in same cycle as pix_req for (0,0).
- Reset values: pix_req=0, pix_x=0, pix_y=0, frame_start=0, running=0, all TMDS = 10'b1101010100, cnt=0.
- Reset mid-frame: immediate return to OFF values; no partial-symbol state retained.
- running=1 from first RUN cycle through the cycle before OFF.

## Test plan
- Reset with rst_n=0, enable=1, tmds_locked=1 -> all outputs at reset values; release -> frame_start and pix_req with pix_x=0,pix_y=0 one cycle after first RUN cycle.
- Full frame, enable held -> exactly 307200 pix_req pulses, 640 per line, frame_start every 420000 cycles; pix_x wraps 639->0 with pix_y increment.
- pix_rgb=0x000000 constant -> first two active symbols on every channel 0x100 then 0x3FF; cnt returns to 0 after blanking.
- Blanking on line 10, h=700 (hsync low, vsync high) -> TMDS_blue=0101010100; h=760 -> 1010101011; lines 490-491 in hsync -> 1101010100; red/green 1101010100 throughout.
- Drop tmds_locked mid-line -> next cycle running=0, pix_req=0, TMDS all 1101010100; re-lock -> restart at (0,0).
- Deassert enable at line 100 -> frame completes (last pix_req at 639,479), then OFF; no further frame_start.
